// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
// Fetch FSM states plus default bus widths and reset PC.
package fetch_pkg;

  localparam int PC_W_DEF    = 8;
  localparam int ADDR_W_DEF  = 16;
  localparam int INSTR_W_DEF = 32;
  localparam int RESET_PC    = 0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_sequencer_if.sv
// Fetch bus: RAM request/response, decode handoff and redirect.
// master = fetch sequencer, slave = RAM/decode/branch side.
interface instruction_fetch_sequencer_if
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH    = PC_W_DEF,
  parameter int ADDR_WIDTH  = ADDR_W_DEF,
  parameter int INSTR_WIDTH = INSTR_W_DEF
);

  logic                   run;
  logic                   mem_req;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic                   mem_rvalid;
  logic [INSTR_WIDTH-1:0] mem_rdata;
  logic                   instr_valid;
  logic                   instr_ready;
  logic [INSTR_WIDTH-1:0] instr_out;
  logic [PC_WIDTH-1:0]    instr_pc;
  logic                   branch_valid;
  logic [PC_WIDTH-1:0]    branch_target;
  logic [15:0]            fetch_count;

  modport master (
    input  run,
    input  mem_rvalid,
    input  mem_rdata,
    input  instr_ready,
    input  branch_valid,
    input  branch_target,
    output mem_req,
    output mem_addr,
    output instr_valid,
    output instr_out,
    output instr_pc,
    output fetch_count
  );

  modport slave (
    output run,
    output mem_rvalid,
    output mem_rdata,
    output instr_ready,
    output branch_valid,
    output branch_target,
    input  mem_req,
    input  mem_addr,
    input  instr_valid,
    input  instr_out,
    input  instr_pc,
    input  fetch_count
  );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register: reset, redirect load, or increment.
// Load wins over increment; increment wraps modulo 2^PC_WIDTH.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH = PC_W_DEF,
  parameter int RST_PC   = RESET_PC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [PC_WIDTH-1:0] target,
  input  logic                inc,
  output logic [PC_WIDTH-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= PC_WIDTH'(RST_PC);
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + PC_WIDTH'(1);
    end
  end

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Fetch sequencer: one outstanding RAM read, registered handoff
// to decode, redirect with squash of an in-flight response.
module instruction_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH    = PC_W_DEF,
  parameter int ADDR_WIDTH  = ADDR_W_DEF,
  parameter int INSTR_WIDTH = INSTR_W_DEF,
  parameter int RST_PC      = RESET_PC
) (
  input logic clk,
  input logic rst,
  instruction_fetch_sequencer_if.master bus
);

  fetch_state_e        state, state_n;
  logic                drop, drop_n;
  logic [PC_WIDTH-1:0] pc;
  logic                req;
  logic                pc_load;
  logic                pc_inc;
  logic                cap;
  logic                handoff;

  fetch_pc_reg #(
    .PC_WIDTH (PC_WIDTH),
    .RST_PC   (RST_PC)
  ) u_pc (
    .clk    (clk),
    .rst    (rst),
    .load   (pc_load),
    .target (bus.branch_target),
    .inc    (pc_inc),
    .pc     (pc)
  );

  assign req          = (state == FETCH) && bus.run && !bus.branch_valid;
  assign bus.mem_req  = req;
  assign bus.mem_addr = ADDR_WIDTH'(pc);

  always_comb begin
    state_n = state;
    drop_n  = drop;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    cap     = 1'b0;
    handoff = 1'b0;
    if (bus.branch_valid) begin
      pc_load = 1'b1;
      unique case (state)
        FETCH: state_n = FETCH;
        WAIT: begin
          if (bus.mem_rvalid) begin
            drop_n  = 1'b0;
            state_n = FETCH;
          end else begin
            drop_n  = 1'b1;
          end
        end
        HOLD:    state_n = FETCH;
        default: state_n = FETCH;
      endcase
    end else begin
      unique case (state)
        FETCH: begin
          if (req) state_n = WAIT;
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            if (drop) begin
              drop_n  = 1'b0;
              state_n = FETCH;
            end else begin
              cap     = 1'b1;
              pc_inc  = 1'b1;
              state_n = HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.instr_ready) begin
            handoff = 1'b1;
            state_n = FETCH;
          end
        end
        default: state_n = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      drop  <= 1'b0;
    end else begin
      state <= state_n;
      drop  <= drop_n;
    end
  end

  // Handoff registers; a redirect clears valid but keeps the stale payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.instr_valid <= 1'b0;
      bus.instr_out   <= '0;
      bus.instr_pc    <= '0;
      bus.fetch_count <= '0;
    end else begin
      if (bus.branch_valid) begin
        bus.instr_valid <= 1'b0;
      end else if (cap) begin
        bus.instr_valid <= 1'b1;
        bus.instr_out   <= bus.mem_rdata;
        bus.instr_pc    <= pc;
      end else if (handoff) begin
        bus.instr_valid <= 1'b0;
        bus.fetch_count <= bus.fetch_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Scoreboard bench for instruction_fetch_sequencer: RAM model,
// expected request/handoff queues and a decoupled monitor.
module tb_instruction_fetch_sequencer;
  import fetch_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  pc;
    logic [15:0] cnt;
  } hand_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   ram_lat = 1;
  int   exp_cnt = 0;

  logic [15:0] exp_addr[$];
  hand_t       exp_hand[$];

  instruction_fetch_sequencer_if #(
    .PC_WIDTH    (8),
    .ADDR_WIDTH  (16),
    .INSTR_WIDTH (32)
  ) bus ();

  instruction_fetch_sequencer #(
    .PC_WIDTH    (8),
    .ADDR_WIDTH  (16),
    .INSTR_WIDTH (32),
    .RST_PC      (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_addr(input logic [7:0] pc);
    exp_addr.push_back({8'h00, pc});
  endtask

  task automatic push_fetch(input logic [7:0] pc);
    hand_t h;
    push_addr(pc);
    h.instr = 32'hA000_0000 + {24'h0, pc};
    h.pc    = pc;
    h.cnt   = 16'(exp_cnt);
    exp_hand.push_back(h);
    exp_cnt++;
  endtask

  // RAM model: latches one request, answers after ram_lat cycles.
  initial begin
    logic        pend;
    int          cnt;
    logic [15:0] paddr;
    pend = 1'b0;
    cnt  = 0;
    paddr = '0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (rst) pend = 1'b0;
      else if (bus.mem_req && !pend) begin
        pend  = 1'b1;
        cnt   = ram_lat;
        paddr = bus.mem_addr;
      end
      @(posedge clk);
      #1;
      bus.mem_rvalid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = 32'hA000_0000 + {16'h0, paddr};
          pend = 1'b0;
        end
      end
    end
  end

  // Monitor: compares every request and every handoff to the queues.
  initial begin
    hand_t h;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.mem_req) begin
          if (exp_addr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req addr %h", bus.mem_addr);
          end else begin
            chk("mem_addr", 32'(bus.mem_addr), 32'(exp_addr.pop_front()));
          end
        end
        if (bus.instr_valid && bus.instr_ready && !bus.branch_valid) begin
          if (exp_hand.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_handoff pc %h", bus.instr_pc);
          end else begin
            h = exp_hand.pop_front();
            chk("instr_out", bus.instr_out, h.instr);
            chk("instr_pc", 32'(bus.instr_pc), 32'(h.pc));
            chk("count_at_handoff", 32'(bus.fetch_count), 32'(h.cnt));
          end
        end
      end
    end
  end

  task automatic fetch_one();
    bit seen;
    seen = 1'b0;
    @(posedge clk);
    #1 bus.run = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_req) seen = 1'b1;
    end
    chk("req_timeout", 32'(seen), 32'd1);
    @(posedge clk);
    #1 bus.run = 1'b0;
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.instr_valid) seen = 1'b1;
    end
    chk("valid_timeout", 32'(seen), 32'd1);
  endtask

  task automatic wait_count(input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.fetch_count == 16'(n)) seen = 1'b1;
    end
    chk("count_timeout", 32'(bus.fetch_count), 32'(n));
  endtask

  task automatic redirect(input logic [7:0] tgt);
    bus.branch_valid  = 1'b1;
    bus.branch_target = tgt;
    @(posedge clk);
    #1 bus.branch_valid = 1'b0;
  endtask

  initial begin
    rst               = 1'b1;
    bus.run           = 1'b0;
    bus.instr_ready   = 1'b1;
    bus.branch_valid  = 1'b0;
    bus.branch_target = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_out", bus.instr_out, 32'd0);
    chk("rst_pc", 32'(bus.instr_pc), 32'd0);
    chk("rst_count", 32'(bus.fetch_count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("run0_noreq", 32'(bus.mem_req), 32'd0);
    end

    // Back-to-back fetches: one request every third cycle.
    push_fetch(8'h00);
    push_fetch(8'h01);
    push_fetch(8'h02);
    @(posedge clk);
    #1 bus.run = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("req_cadence", 32'(bus.mem_req), 32'(i % 3 == 0));
    end
    @(posedge clk);
    #1 bus.run = 1'b0;
    bus.instr_ready = 1'b0;
    @(negedge clk);
    chk("count3", 32'(bus.fetch_count), 32'd3);

    // Decode stall in HOLD.
    push_fetch(8'h03);
    fetch_one();
    wait_valid();
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", 32'(bus.instr_valid), 32'd1);
      chk("stall_out", bus.instr_out, 32'hA000_0003);
      chk("stall_pc", 32'(bus.instr_pc), 32'h03);
    end
    @(posedge clk);
    #1 bus.instr_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("stall_count", 32'(bus.fetch_count), 32'd4);
    chk("stall_cleared", 32'(bus.instr_valid), 32'd0);

    // Redirect while waiting on a slow RAM: late response squashed.
    ram_lat = 2;
    push_addr(8'h04);
    fetch_one();
    redirect(8'h40);
    repeat (3) begin
      @(negedge clk);
      chk("squash_valid", 32'(bus.instr_valid), 32'd0);
    end
    push_fetch(8'h40);
    fetch_one();
    wait_count(5);
    ram_lat = 1;

    // Redirect coincident with the RAM response.
    push_addr(8'h41);
    fetch_one();
    redirect(8'h50);
    @(negedge clk);
    chk("brrv_valid", 32'(bus.instr_valid), 32'd0);
    chk("brrv_count", 32'(bus.fetch_count), 32'd5);
    push_fetch(8'h50);
    fetch_one();
    wait_count(6);

    // Redirect coincident with decode ready in HOLD.
    @(posedge clk);
    #1 bus.instr_ready = 1'b0;
    push_addr(8'h51);
    fetch_one();
    wait_valid();
    @(posedge clk);
    #1 bus.instr_ready = 1'b1;
    redirect(8'h60);
    @(negedge clk);
    chk("brhold_count", 32'(bus.fetch_count), 32'd6);
    chk("brhold_valid", 32'(bus.instr_valid), 32'd0);
    push_fetch(8'h60);
    fetch_one();
    wait_count(7);

    // PC wrap 8'hFF -> 8'h00.
    @(posedge clk);
    #1;
    redirect(8'hFF);
    push_fetch(8'hFF);
    push_fetch(8'h00);
    fetch_one();
    wait_count(8);
    fetch_one();
    wait_count(9);

    // Reset mid-WAIT: next cycle requests RESET_PC.
    ram_lat = 2;
    push_addr(8'h01);
    fetch_one();
    rst = 1'b1;
    bus.run = 1'b1;
    bus.instr_ready = 1'b0;
    push_addr(8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstw_valid", 32'(bus.instr_valid), 32'd0);
    chk("rstw_count", 32'(bus.fetch_count), 32'd0);
    chk("rstw_req", 32'(bus.mem_req), 32'd1);
    chk("rstw_addr", 32'(bus.mem_addr), 32'd0);
    @(posedge clk);
    #1 bus.run = 1'b0;

    // Reset mid-HOLD with run low afterwards.
    wait_valid();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rsth_valid", 32'(bus.instr_valid), 32'd0);
    chk("rsth_out", bus.instr_out, 32'd0);
    chk("rsth_count", 32'(bus.fetch_count), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rsth_noreq", 32'(bus.mem_req), 32'd0);
    end

    ram_lat = 1;
    bus.instr_ready = 1'b1;
    exp_cnt = 0;
    push_fetch(8'h00);
    fetch_one();
    wait_count(1);

    repeat (3) @(negedge clk);
    chk("addr_q_left", 32'(exp_addr.size()), 32'd0);
    chk("hand_q_left", 32'(exp_hand.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_sequencer.md
Name: instruction_fetch_sequencer

Overview:
Fetch-side counterpart of the instruction latch stage. It owns the program counter and issues read requests to instruction RAM. It captures each returned word and hands it to the decode-side latch through a valid/ready handshake, together with the PC it came from. It supports branch/jump redirect with squashing of in-flight fetches, and a run enable for halting.

Parameters:
PC_WIDTH, 8, program counter width (matches the pc_count bus consumed downstream)
ADDR_WIDTH, 16, RAM address width; PC is zero-extended into it
INSTR_WIDTH, 32, instruction word width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  single system clock; all state changes on posedge
rst  in  1  synchronous, active-high reset
run  in  1  fetch enable; low = no new requests issued
mem_req  out  1  read request to instruction RAM; one-cycle pulse, combinational from state
mem_addr  out  ADDR_WIDTH  {zeros, pc}; meaningful only while mem_req=1
mem_rvalid  in  1  RAM read data valid; arrives ≥1 cycle after mem_req
mem_rdata  in  INSTR_WIDTH  RAM read data, sampled when mem_rvalid=1
instr_valid  out  1  instr_out/instr_pc hold a fetched instruction
instr_ready  in  1  decode latch accepts the instruction this cycle
instr_out  out  INSTR_WIDTH  fetched instruction (registered)
instr_pc  out  PC_WIDTH  PC of instr_out (registered; drives the downstream pc_count)
branch_valid  in  1  redirect request, one cycle
branch_target  in  PC_WIDTH  new PC for the redirect
fetch_count  out  16  number of instructions handed off; wraps at 16'hFFFF→0

Behaviour:
- Reset (rst=1 at posedge) sets:
  - state=FETCH, pc=RESET_PC, drop=0
  - instr_valid=0, instr_out=0, instr_pc=0, fetch_count=0
- Reset overrides every other input. Instruction RAM shares rst, so no response survives reset. Any mem_rvalid seen outside WAIT is ignored.
- Only one request is ever outstanding.
- mem_req = (state==FETCH) && run && !branch_valid. There is no stale-address request on a redirect cycle.
- FSM states FETCH, WAIT, HOLD:
  - FETCH: if mem_req, go WAIT. Otherwise stay. run=0 is an indefinite stall.
  - WAIT: on mem_rvalid:
    - drop=1 or branch_valid=1: discard the data, clear drop, go FETCH.
    - Otherwise: instr_out<=mem_rdata, instr_pc<=pc, pc<=pc+1 (mod 2^PC_WIDTH, 8'hFF→8'h00), instr_valid<=1, go HOLD.
  - HOLD: instr_valid=1. On instr_ready: instr_valid<=0, fetch_count<=fetch_count+1, go FETCH.
- Redirect (branch_valid=1), highest priority after reset, in any state: pc<=branch_target and instr_valid<=0 next cycle.
  - FETCH: stay FETCH; the request to branch_target issues the following cycle.
  - WAIT without same-cycle mem_rvalid: drop<=1, stay WAIT.
  - WAIT with same-cycle mem_rvalid: discard the data, go FETCH.
  - HOLD: go FETCH. A same-cycle instr_ready does not count as a handoff, and fetch_count is unchanged.
- A second redirect while drop=1 only updates pc.
- Minimum latency is 3 cycles per instruction: request, response, handoff. Steady state with 1-cycle RAM and ready tied high gives 1 instruction per 3 cycles.
- instr_out and instr_pc are stable while instr_valid=1 and instr_ready=0.
- run=0 does not cancel an outstanding request or a held instruction.

Decomposition:
- Shared package fetch_pkg:
  - state enum (FETCH/WAIT/HOLD)
  - PC_WIDTH/ADDR_WIDTH/INSTR_WIDTH defaults
  - RESET_PC
- Optional sub-module fetch_pc_reg: PC register with load/increment/reset. The rest stays in one module.

Test Plan:
- Reset, run=1, RAM returns mem_rdata=32'hA0000000+addr after 1 cycle, ready=1 → mem_addr 0,1,2 on cycles 0,3,6. instr_out=32'hA0000000 with instr_pc=0, and fetch_count=3 after the third handoff.
- instr_ready held low 5 cycles in HOLD → instr_valid stays 1, instr_out/instr_pc unchanged, no mem_req. On ready=1, one handoff occurs and fetch_count increments once.
- branch_valid with target=8'h40 while in WAIT, RAM responds 2 cycles later → response discarded, instr_valid never rises for it. The next mem_addr=16'h0040 and the next handoff has instr_pc=8'h40.
- branch_valid coincident with mem_rvalid, and separately coincident with instr_ready in HOLD → no handoff, fetch_count unchanged, next fetch from branch_target.
- Branch to 8'hFF, fetch twice → instr_pc 8'hFF then 8'h00 (PC wraps), mem_addr 16'h00FF then 16'h0000.
- rst asserted mid-WAIT and mid-HOLD → next cycle instr_valid=0, fetch_count=0, mem_req=1 with mem_addr=RESET_PC. run=0 after reset → mem_req stays 0.
